countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning counter and load-value width in bits.
REQ-002 The module SHALL have parameter PRESCALE, default 1, meaning enabled clk cycles per decrement (legal range 1..256).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port load, input, 1 bit: a 1-cycle request to load load_val and start.
REQ-006 The module SHALL have port load_val, input, WIDTH bits: the start and reload value.
REQ-007 The module SHALL have port en, input, 1 bit: count enable; the timer pauses while low.
REQ-008 The module SHALL have port auto_reload, input, 1 bit: 1 = periodic mode, 0 = one-shot mode.
REQ-009 The module SHALL have port count, output, WIDTH bits: the current remaining count (registered).
REQ-010 The module SHALL have port busy, output, 1 bit: high while state is RUN or HOLD.
REQ-011 The module SHALL have port done, output, 1 bit: a registered 1-cycle pulse at expiry.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and HOLD.
REQ-013 A load in any state SHALL, on the next edge, set count=load_val, capture reload_reg=load_val and clear the prescale counter.
- Next state: RUN if load_val!=0 and en=1; HOLD if load_val!=0 and en=0; IDLE if load_val==0.
- done stays 0 on that edge.
REQ-014 load SHALL have priority over a decrement, expiry and the en transitions in the same cycle.
REQ-015 In RUN with en=1, the prescale counter SHALL advance each cycle; every PRESCALE-th enabled cycle is a tick.
REQ-016 A tick with count>1 SHALL decrement count by exactly 1 on the next edge, with no wrap below 0.
REQ-017 A tick with count==1 SHALL pulse done=1 for exactly one cycle, aligned with the count update.
- If auto_reload=1: count<=reload_reg and the state stays RUN.
- If auto_reload=0: count<=0 and the state goes to IDLE.
REQ-018 In RUN, en=0 SHALL move the state to HOLD; count and the prescale counter are frozen.
REQ-019 In HOLD, en=1 SHALL return the state to RUN; counting resumes from the frozen prescale phase.
REQ-020 In IDLE, en and auto_reload SHALL be ignored and count SHALL hold its value.
REQ-021 auto_reload SHALL be sampled only on the expiry cycle.
REQ-022 With PRESCALE=1 and no pause, done SHALL pulse exactly N cycles after the load edge for load_val=N.
REQ-023 In periodic mode, the done period SHALL be N*PRESCALE enabled cycles.
REQ-024 busy SHALL be registered and SHALL equal (state!=IDLE) with no extra latency.
REQ-025 load_val=2^WIDTH-1 SHALL count the full range with no overflow.

Reset
REQ-026 While rst=0, the module SHALL asynchronously force state=IDLE, count=0, done=0, busy=0, reload_reg=0 and the prescale counter to 0.
REQ-027 Reset asserted mid-count SHALL abort the count with no done pulse.
REQ-028 After rst is released, the module SHALL stay in IDLE until a load occurs.

Structure
REQ-029 The state enum typedef (IDLE, RUN, HOLD) SHALL live in package countdown_pkg.
REQ-030 The prescaler SHALL be a sub-module tick_gen with ports clk, rst, clear, en and tick.
- When PRESCALE=1, tick_gen SHALL reduce to tick=en.
REQ-031 count, done and busy SHALL be driven directly from flops, with no combinational outputs.

Verification
REQ-032 The bench SHALL check: rst low mid-count (count=5) -> count=0, busy=0, done=0 immediately; no done after rst is released.
REQ-033 The bench SHALL check: PRESCALE=1, load_val=3, en=1, auto_reload=0 -> count 3,2,1,0 on successive edges; done high only with count=0; busy falls with it.
REQ-034 The bench SHALL check: load_val=4, auto_reload=1, en=1 for 12 cycles -> done pulses every 4 cycles; count sequence 4,3,2,1,4,3,2,1,...
REQ-035 The bench SHALL check: load_val=5 with en dropped for 3 cycles at count=3 -> state HOLD; count stays 3; done is delayed by exactly 3 cycles.
REQ-036 The bench SHALL check: load_val=9 reloaded at count=1 in the same cycle as the expiry tick -> count=9, no done pulse; load_val=0 -> IDLE, no done.
REQ-037 The bench SHALL check: PRESCALE=4, load_val=2 -> count steps every 4 enabled cycles; done is 8 cycles after load.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
package countdown_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles; clear restarts the phase.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);
  generate
    if (PRESCALE == 1) begin : g_bypass
      assign tick = en;
    end else begin : g_div
      localparam int CW = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_cnt <= '0;
        else if (clear)              r_cnt <= '0;
        else if (en && r_cnt == LAST) r_cnt <= '0;
        else if (en)                 r_cnt <= r_cnt + CW'(1);
      end

      assign tick = en && (r_cnt == LAST);
    end
  endgenerate
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, pause/resume and one-shot or periodic expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  state_t           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_count, w_nxt_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done, r_busy, w_nxt_done;
  logic             w_tick, w_tg_en;

  // A HOLD->RUN cycle with en=1 already counts, so a pause of k cycles delays expiry by exactly k.
  assign w_tg_en = en && (r_state != IDLE) && !load;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (load),
    .en    (w_tg_en),
    .tick  (w_tick)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_count = r_count;
    w_nxt_done  = 1'b0;
    if (load) begin
      w_nxt_count = load_val;
      if (load_val == '0) w_nxt_state = IDLE;
      else                w_nxt_state = en ? RUN : HOLD;
    end else begin
      case (r_state)
        RUN, HOLD: begin
          if (!en) begin
            w_nxt_state = HOLD;
          end else begin
            w_nxt_state = RUN;
            if (w_tick) begin
              if (r_count == WIDTH'(1)) begin
                w_nxt_done = 1'b1;
                if (auto_reload) begin
                  w_nxt_count = r_reload;
                end else begin
                  w_nxt_count = '0;
                  w_nxt_state = IDLE;
                end
              end else if (r_count > WIDTH'(1)) begin
                w_nxt_count = r_count - WIDTH'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_count  <= w_nxt_count;
      r_done   <= w_nxt_done;
      r_busy   <= (w_nxt_state != IDLE);
      if (load) r_reload <= load_val;
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: PRESCALE=1 and PRESCALE=4 instances.
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0, load4 = 1'b0;
  logic [7:0] load_val = '0;
  logic       en = 1'b0, auto_reload = 1'b0;
  logic [7:0] count, count4;
  logic       busy, done, busy4, done4;
  int         nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .count(count), .busy(busy), .done(done)
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .load(load4), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .count(count4), .busy(busy4), .done(done4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] c, input logic b, input logic d,
                     input logic [7:0] ec, input logic eb, input logic ed);
    nvec++;
    if (c !== ec || b !== eb || d !== ed) begin
      nerr++;
      $display("FAIL %s: count=%0d busy=%b done=%b, required count=%0d busy=%b done=%b",
               name, c, b, d, ec, eb, ed);
    end
  endtask

  task automatic test_reset();
    logic seen;
    #1;
    chk("reset_hold", count, busy, done, 8'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    chk("idle_after_release", count, busy, done, 8'd0, 1'b0, 1'b0);
    en = 1'b1; load_val = 8'd8; load = 1'b1;
    step();
    load = 1'b0;
    chk("load8", count, busy, done, 8'd8, 1'b1, 1'b0);
    step(); step(); step();
    chk("count5", count, busy, done, 8'd5, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", count, busy, done, 8'd0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    nvec++;
    if (seen) begin
      nerr++;
      $display("FAIL no_done_after_reset: done/busy seen high, required low");
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] ec [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    logic       eb [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1; auto_reload = 1'b0; load_val = 8'd3; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("oneshot[%0d]", i), count, busy, done, ec[i], eb[i], ed[i]);
      if (i < 4) step();
    end
  endtask

  task automatic test_periodic();
    en = 1'b1; auto_reload = 1'b1; load_val = 8'd4; load = 1'b1;
    step();
    load = 1'b0;
    chk("periodic_load", count, busy, done, 8'd4, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("periodic[%0d]", k), count, busy, done,
          (k % 4 == 0) ? 8'd4 : 8'(4 - k % 4), 1'b1, (k % 4 == 0));
    end
    auto_reload = 1'b0; load_val = 8'd0; load = 1'b1;
    step();
    load = 1'b0;
    chk("periodic_stop", count, busy, done, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_pause();
    en = 1'b1; auto_reload = 1'b0; load_val = 8'd5; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    chk("pause_at3", count, busy, done, 8'd3, 1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold[%0d]", i), count, busy, done, 8'd3, 1'b1, 1'b0);
    end
    en = 1'b1;
    step();
    chk("resume2", count, busy, done, 8'd2, 1'b1, 1'b0);
    step();
    chk("resume1", count, busy, done, 8'd1, 1'b1, 1'b0);
    step();
    chk("pause_done", count, busy, done, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reload_at_expiry();
    en = 1'b1; auto_reload = 1'b0; load_val = 8'd3; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    chk("pre_reload1", count, busy, done, 8'd1, 1'b1, 1'b0);
    load_val = 8'd9; load = 1'b1;
    step();
    load = 1'b0;
    chk("reload9", count, busy, done, 8'd9, 1'b1, 1'b0);
    step();
    chk("reload_dec", count, busy, done, 8'd8, 1'b1, 1'b0);
    load_val = 8'd0; load = 1'b1;
    step();
    load = 1'b0;
    chk("load_zero", count, busy, done, 8'd0, 1'b0, 1'b0);
    step();
    chk("load_zero_idle", count, busy, done, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_prescale();
    en = 1'b1; auto_reload = 1'b0; load_val = 8'd2; load4 = 1'b1;
    step();
    load4 = 1'b0;
    chk("ps_load", count4, busy4, done4, 8'd2, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("ps[%0d]", k), count4, busy4, done4,
          (k < 4) ? 8'd2 : (k < 8) ? 8'd1 : 8'd0, (k < 8), (k == 8));
    end
  endtask

  task automatic test_full_range();
    int cyc;
    en = 1'b1; auto_reload = 1'b0; load_val = 8'd255; load = 1'b1;
    step();
    load = 1'b0;
    chk("full_load", count, busy, done, 8'd255, 1'b1, 1'b0);
    step();
    chk("full_dec", count, busy, done, 8'd254, 1'b1, 1'b0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
    nvec++;
    if (cyc != 255) begin
      nerr++;
      $display("FAIL full_range_latency: done after %0d cycles, required 255", cyc);
    end
    chk("full_end", count, busy, done, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_reload_at_expiry();
    test_prescale();
    test_full_range();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
